// File: rtl/vx_tcu_drl_step_sched_pkg.sv
// TCU format IDs and format-to-step geometry helpers shared by the DRL step sequencer.
// Pure definitions and functions, no latency. No flow control of its own.
// Skip-empty mode (VX_TCU_DRL_SKIP_EMPTY_EN) reuses the same helpers.
package vx_tcu_drl_step_sched_pkg;

    localparam int TCU_MAX_INPUTS = 32;
    localparam int TCU_DRL_N      = 2;
    localparam int TCU_TCK        = 2 * TCU_DRL_N;
    localparam int MAX_STEPS      = TCU_MAX_INPUTS / TCU_TCK;

    localparam logic [3:0] TCU_FP32_ID = 4'd0;
    localparam logic [3:0] TCU_FP16_ID = 4'd1;
    localparam logic [3:0] TCU_BF16_ID = 4'd2;
    localparam logic [3:0] TCU_FP8_ID  = 4'd3;
    localparam logic [3:0] TCU_BF8_ID  = 4'd4;
    localparam logic [3:0] TCU_I8_ID   = 4'd9;
    localparam logic [3:0] TCU_U8_ID   = 4'd10;
    localparam logic [3:0] TCU_I4_ID   = 4'd11;
    localparam logic [3:0] TCU_U4_ID   = 4'd12;

    typedef enum logic [2:0] {FC_W32, FC_W16, FC_W8, FC_W4, FC_BAD} fmt_class_e;
    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    function automatic fmt_class_e fmt_class(input logic [3:0] fmt);
        case (fmt)
            TCU_FP32_ID:                                 return FC_W32;
            TCU_FP16_ID, TCU_BF16_ID:                    return FC_W16;
            TCU_FP8_ID, TCU_BF8_ID, TCU_I8_ID, TCU_U8_ID: return FC_W8;
            TCU_I4_ID, TCU_U4_ID:                        return FC_W4;
            default:                                     return FC_BAD;
        endcase
    endfunction

    function automatic logic fmt_supported(input logic [3:0] fmt);
        return fmt_class(fmt) != FC_BAD;
    endfunction

    // Mask bits consumed per lane; the step stride is this times TCK.
    function automatic int fmt_stride_mul(input logic [3:0] fmt);
        case (fmt_class(fmt))
            FC_W8:   return 2;
            FC_W4:   return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int fmt_nstep(input logic [3:0] fmt, input int max_steps);
        return fmt_supported(fmt) ? max_steps / fmt_stride_mul(fmt) : 1;
    endfunction

endpackage

// File: rtl/vx_tcu_drl_step_sched_mask.sv
// Picks the TCK per-lane enables of one step out of its mask window for a given format.
// Combinational, zero latency. No flow control.
module vx_tcu_drl_step_sched_mask
    import vx_tcu_drl_step_sched_pkg::*;
#(
    parameter int TCK = 4
) (
    input  logic [3:0]       fmt,
    input  logic [4*TCK-1:0] win,
    output logic [TCK-1:0]   lane_mask
);

    localparam int SEL_W = $clog2(4 * TCK);

    logic [SEL_W-1:0] sel;
    int               pitch;
    logic             half;

    assign pitch = fmt_stride_mul(fmt);
    assign half  = fmt_class(fmt) == FC_W32;

    // FP32 elements occupy two lanes, so only even lanes carry an enable.
    always_comb begin
        lane_mask = '0;
        sel       = '0;
        for (int i = 0; i < TCK; i++) begin
            sel          = SEL_W'(pitch * i);
            lane_mask[i] = fmt_supported(fmt) && !(half && (i % 2) == 1) && win[sel];
        end
    end

endmodule

// File: rtl/vx_tcu_drl_step_sched.sv
// Splits a TCU operand-valid mask into per-step TCK-lane masks for the DRL lanes.
// Latency: first step one cycle after request accept, then one step per cycle.
// Backpressure: step_* hold while step_ready=0; req_ready only when idle or on last-step fire.
// Optional VX_TCU_DRL_SKIP_EMPTY_EN skips steps whose lane mask is all-zero.
module vx_tcu_drl_step_sched
    import vx_tcu_drl_step_sched_pkg::*;
#(
    parameter int N       = 2,
    parameter int TCK     = 2 * N,
    parameter int MASK_W  = TCU_MAX_INPUTS,
    parameter int TAG_W   = 8,
    parameter int STEP_IW = $clog2(MASK_W / TCK)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_fmt,
    input  logic [MASK_W-1:0]  req_vld_mask,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               step_valid,
    input  logic               step_ready,
    output logic [TCK-1:0]     step_lane_mask,
    output logic [STEP_IW-1:0] step_idx,
    output logic               step_last,
    output logic               step_err,
    output logic [TAG_W-1:0]   step_tag,
    output logic               busy
);

    localparam int MAX_STEP_CNT = MASK_W / TCK;
    localparam int WIN_W        = 4 * TCK;
    localparam int SI_W         = STEP_IW + 1;

    state_e              state_q, state_d;
    logic [3:0]          fmt_q;
    logic [MASK_W-1:0]   mask_q;
    logic                step_fire, req_fire, load;
    logic [3:0]          src_fmt;
    logic [MASK_W-1:0]   src_mask;
    logic [SI_W-1:0]     src_start;
    int                  src_stride, src_nstep;
    logic [STEP_IW-1:0]  nxt_idx;
    logic [TCK-1:0]      nxt_mask;
    logic                nxt_last;

    assign busy       = state_q == ST_RUN;
    assign step_valid = busy;
    assign step_fire  = step_valid & step_ready;
    assign req_ready  = reset_n & ~flush & ((state_q == ST_IDLE) | (step_fire & step_last));
    assign req_fire   = req_valid & req_ready;
    assign load       = req_fire | (step_fire & ~step_last & ~flush);

    // The next step is searched either in the incoming request or in the held one.
    always_comb begin
        src_fmt   = req_fire ? req_fmt : fmt_q;
        src_mask  = req_fire ? req_vld_mask : mask_q;
        src_start = req_fire ? '0 : SI_W'(step_idx) + SI_W'(1);
    end

    assign src_stride = fmt_stride_mul(src_fmt) * TCK;
    assign src_nstep  = fmt_nstep(src_fmt, MAX_STEP_CNT);

`ifdef VX_TCU_DRL_SKIP_EMPTY_EN
    logic [WIN_W-1:0] cand_win  [MAX_STEP_CNT];
    logic [TCK-1:0]   cand_mask [MAX_STEP_CNT];
    logic             found;

    always_comb begin
        for (int s = 0; s < MAX_STEP_CNT; s++) begin
            cand_win[s] = WIN_W'(src_mask >> (s * src_stride));
        end
    end

    for (genvar g = 0; g < MAX_STEP_CNT; g++) begin : g_cand
        vx_tcu_drl_step_sched_mask #(.TCK(TCK)) u_mask (
            .fmt       (src_fmt),
            .win       (cand_win[g]),
            .lane_mask (cand_mask[g])
        );
    end

    // Lowest non-empty step at or after src_start; none left means a single empty final step.
    always_comb begin
        found    = 1'b0;
        nxt_idx  = STEP_IW'(src_nstep - 1);
        nxt_mask = '0;
        nxt_last = 1'b1;
        for (int s = 0; s < MAX_STEP_CNT; s++) begin
            if (!found && s >= int'(src_start) && s < src_nstep && (|cand_mask[s])) begin
                found    = 1'b1;
                nxt_idx  = STEP_IW'(s);
                nxt_mask = cand_mask[s];
            end
        end
        for (int s = 0; s < MAX_STEP_CNT; s++) begin
            if (found && s > int'(nxt_idx) && s < src_nstep && (|cand_mask[s])) begin
                nxt_last = 1'b0;
            end
        end
    end
`else
    logic [WIN_W-1:0] cur_win;

    assign cur_win  = WIN_W'(src_mask >> (int'(src_start) * src_stride));
    assign nxt_idx  = STEP_IW'(src_start);
    assign nxt_last = int'(src_start) == src_nstep - 1;

    vx_tcu_drl_step_sched_mask #(.TCK(TCK)) u_mask (
        .fmt       (src_fmt),
        .win       (cur_win),
        .lane_mask (nxt_mask)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (req_fire) begin
            state_d = ST_RUN;
        end else if (step_fire && step_last) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fmt_q          <= '0;
            mask_q         <= '0;
            step_idx       <= '0;
            step_lane_mask <= '0;
            step_last      <= 1'b0;
            step_err       <= 1'b0;
            step_tag       <= '0;
        end else if (load) begin
            step_idx       <= nxt_idx;
            step_lane_mask <= nxt_mask;
            step_last      <= nxt_last;
            step_err       <= ~fmt_supported(src_fmt);
            if (req_fire) begin
                fmt_q    <= req_fmt;
                mask_q   <= req_vld_mask;
                step_tag <= req_tag;
            end
        end
    end

endmodule
